// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one UART transmitter among NUM_REQ byte sources. Sources are
//   served round-robin. A packet lock keeps a multi-byte packet from one
//   source contiguous. The block also owns the UART baud selection and only
//   applies baud changes between packets.
//
// Handshake: source i hands over a byte in the cycle where
//   req_valid[i] & req_ready[i] = 1. req_ready is combinational and is only
//   raised while the scheduler is in IDLE. A source must hold req_data and
//   req_last stable while req_valid is high and req_ready is low.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   req_valid/last  per-source byte valid / end-of-packet marker
//   req_data        per-source byte, source i at [8i+7:8i]
//   req_ready       per-source accept pulse
//   cfg_wr/cfg_sel  baud change request (code 3 ignored)
//   cfg_pending     a baud change is waiting to be applied
//   uart_wr/dat     one-cycle transmit strobe and byte to UART
//   uart_tx_busy    UART transmitter busy
//   uart_speed_sel  one-hot baud select to UART
//   grant_active    byte in flight or packet lock held
//   grant_id        current or most recent owner
//   err_timeout     one-cycle pulse when the UART never raised busy
//   state_dbg       current FSM state, for observation only

module uart_tx_scheduler #(
  parameter int          NUM_REQ       = 4,
  parameter int          BUSY_TIMEOUT  = 16,
  parameter int          LOCK_TIMEOUT  = 1000000,
  parameter logic [1:0]  DEFAULT_SPEED = 2'd0,
  localparam int         IDW           = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 cfg_wr,
  input  logic [1:0]           cfg_sel,
  output logic                 cfg_pending,
  output logic                 uart_wr,
  output logic [7:0]           uart_dat,
  input  logic                 uart_tx_busy,
  output logic [3:0]           uart_speed_sel,
  output logic                 grant_active,
  output logic [IDW-1:0]       grant_id,
  output logic                 err_timeout,
  output logic [1:0]           state_dbg
);

  localparam int BT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam int LT_W = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [IDW-1:0]   ptr;
  logic             lock;
  logic             cap_last;
  logic [1:0]       pend_code;
  logic [BT_W-1:0]  busy_cnt;
  logic [LT_W-1:0]  stall_cnt;

  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   cand;
  int               idx;
  logic             grant;
  logic             apply;
  logic             stalling;
  logic             stall_drop;

  function automatic logic [3:0] speed_onehot(input logic [1:0] code);
    case (code)
      2'd1:    speed_onehot = 4'b0100;
      2'd2:    speed_onehot = 4'b0010;
      default: speed_onehot = 4'b1000;
    endcase
  endfunction

  // Winner selection. With the lock held only the owner may win; otherwise
  // the search starts just above the last winner and wraps.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    idx   = 0;
    if (lock) begin
      found = req_valid[grant_id];
      win   = grant_id;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx  = (int'(ptr) + k) % NUM_REQ;
        cand = IDW'(idx);
        if (!found && req_valid[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
    end
  end

  // Owner holds the lock but has nothing to send while we sit in IDLE.
  assign stalling   = (state == IDLE) && lock && !req_valid[grant_id];
  assign stall_drop = stalling && (stall_cnt == LT_W'(LOCK_TIMEOUT - 1));

  always_comb begin
    state_n     = state;
    req_ready   = '0;
    uart_wr     = 1'b0;
    err_timeout = 1'b0;
    grant       = 1'b0;
    apply       = 1'b0;
    case (state)
      IDLE: begin
        // A pending baud change takes the whole cycle; nothing is granted.
        if (!lock && cfg_pending) begin
          apply = 1'b1;
        end else if (found) begin
          grant          = 1'b1;
          req_ready[win] = 1'b1;
          state_n        = ISSUE;
        end
      end
      ISSUE: begin
        uart_wr = 1'b1;
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_n = WAIT_DONE;
        end else if (busy_cnt == BT_W'(BUSY_TIMEOUT - 1)) begin
          err_timeout = 1'b1;
          state_n     = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= IDW'(NUM_REQ - 1);
      lock           <= 1'b0;
      cap_last       <= 1'b0;
      grant_id       <= '0;
      uart_dat       <= '0;
      pend_code      <= '0;
      cfg_pending    <= 1'b0;
      uart_speed_sel <= speed_onehot(DEFAULT_SPEED);
      busy_cnt       <= '0;
      stall_cnt      <= '0;
    end else begin
      state <= state_n;

      // busy_cnt = cycles already spent in WAIT_BUSY
      if (state == ISSUE)          busy_cnt <= '0;
      else if (state == WAIT_BUSY) busy_cnt <= busy_cnt + 1'b1;

      if (grant) begin
        grant_id <= win;
        ptr      <= win;
        uart_dat <= req_data[{win, 3'b000} +: 8];
        cap_last <= req_last[win];
      end

      if (err_timeout)                               lock <= 1'b0;
      else if (state == WAIT_DONE && !uart_tx_busy)  lock <= ~cap_last;
      else if (stall_drop)                           lock <= 1'b0;

      if (stalling && !stall_drop) stall_cnt <= stall_cnt + 1'b1;
      else                         stall_cnt <= '0;

      // A write landing on the apply cycle wins and stays pending.
      if (apply) begin
        uart_speed_sel <= speed_onehot(pend_code);
        cfg_pending    <= 1'b0;
      end
      if (cfg_wr && cfg_sel != 2'd3) begin
        pend_code   <= cfg_sel;
        cfg_pending <= 1'b1;
      end
    end
  end

  assign grant_active = (state != IDLE) || lock;
  assign state_dbg    = state;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

  localparam int NR = 4;
  localparam int BT = 16;
  localparam int LT = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_last;
  logic [NR*8-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            cfg_wr;
  logic [1:0]      cfg_sel;
  logic            cfg_pending;
  logic            uart_wr;
  logic [7:0]      uart_dat;
  logic            uart_tx_busy;
  logic [3:0]      uart_speed_sel;
  logic            grant_active;
  logic [1:0]      grant_id;
  logic            err_timeout;
  logic [1:0]      state_dbg;

  uart_tx_scheduler #(
    .NUM_REQ(NR), .BUSY_TIMEOUT(BT), .LOCK_TIMEOUT(LT), .DEFAULT_SPEED(2'd0)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_pending(cfg_pending),
    .uart_wr(uart_wr), .uart_dat(uart_dat), .uart_tx_busy(uart_tx_busy),
    .uart_speed_sel(uart_speed_sel),
    .grant_active(grant_active), .grant_id(grant_id),
    .err_timeout(err_timeout), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         n_err  = 0;
  logic [7:0] exp_q[$];
  logic [8:0] src_q[NR][$];   // {last, data}
  logic [7:0] nobusy_byte = 8'hD4;
  int         fall_cyc = 0;

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_ready(input logic [1:0] i, input string nm);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!req_ready[i] && n < 300);
    n_cmp++;
    if (!req_ready[i]) begin
      n_fail++;
      $display("FAIL %s: req_ready[%0d] got 0, expected 1 within 300 cycles", nm, i);
    end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((exp_q.size() != 0 || grant_active) && n < 3000);
    n_cmp++;
    if (exp_q.size() != 0 || grant_active) begin
      n_fail++;
      $display("FAIL %s: got %0d bytes outstanding / active=%0b, expected 0 / 0",
               nm, exp_q.size(), grant_active);
    end
  endtask

  task automatic load(input int s, input logic last, input logic [7:0] d);
    src_q[s].push_back({last, d});
  endtask

  // ---------------- source driver ----------------
  initial begin
    logic [NR-1:0] pop_pend;
    pop_pend  = '0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (pop_pend[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        pop_pend[i] = 1'b0;
        if (src_q[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_last[i]        = src_q[i][0][8];
          req_data[8*i +: 8] = src_q[i][0][7:0];
        end else begin
          req_valid[i]       = 1'b0;
          req_last[i]        = 1'b0;
          req_data[8*i +: 8] = '0;
        end
      end
      #1;
      for (int i = 0; i < NR; i++)
        if (req_ready[i] && req_valid[i]) pop_pend[i] = 1'b1;
    end
  end

  // ---------------- UART model ----------------
  initial begin
    int bleft;
    bleft        = 0;
    uart_tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_wr && uart_dat != nobusy_byte) begin
        uart_tx_busy = 1'b1;
        bleft        = 6;
      end else if (bleft > 0) begin
        bleft--;
        if (bleft == 0) begin
          uart_tx_busy = 1'b0;
          fall_cyc     = cyc;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic       ready_prev;
    logic       wr_prev;
    int         last_wr_cyc;
    logic [7:0] e;
    ready_prev  = 1'b0;
    wr_prev     = 1'b0;
    last_wr_cyc = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        ready_prev = 1'b0;
        wr_prev    = 1'b0;
      end else begin
        if (|req_ready) begin
          n_cmp++;
          if (ready_prev || !$onehot(req_ready)) begin
            n_fail++;
            $display("FAIL ready_pulse: got req_ready=%b prev=%0b, expected one-hot single cycle",
                     req_ready, ready_prev);
          end
        end
        if (uart_wr) begin
          n_cmp++;
          if (!ready_prev || wr_prev) begin
            n_fail++;
            $display("FAIL wr_timing: got prev_ready=%0b prev_wr=%0b, expected 1 / 0",
                     ready_prev, wr_prev);
          end
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL uart_byte: got 0x%02h, expected no strobe", uart_dat);
          end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if (uart_dat !== e) begin
              n_fail++;
              $display("FAIL uart_byte: got 0x%02h, expected 0x%02h", uart_dat, e);
            end
          end
          last_wr_cyc = cyc;
        end
        if (err_timeout) begin
          n_err++;
          n_cmp++;
          if (cyc - last_wr_cyc != BT) begin
            n_fail++;
            $display("FAIL err_delay: got %0d cycles after uart_wr, expected %0d",
                     cyc - last_wr_cyc, BT);
          end
        end
        ready_prev = |req_ready;
        wr_prev    = uart_wr;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got no end of test, expected finish within 50000 cycles");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    rst     = 1'b1;
    cfg_wr  = 1'b0;
    cfg_sel = 2'd0;
    repeat (3) tick();

    // reset values
    check("rst_uart_wr",  uart_wr,        0);
    check("rst_uart_dat", uart_dat,       0);
    check("rst_ready",    req_ready,      0);
    check("rst_active",   grant_active,   0);
    check("rst_grant_id", grant_id,       0);
    check("rst_err",      err_timeout,    0);
    check("rst_pending",  cfg_pending,    0);
    check("rst_speed",    uart_speed_sel, 4'b1000);
    rst = 1'b0;
    repeat (2) tick();

    // T2 round robin, no locks
    load(0, 1, 8'hA0); load(1, 1, 8'hA1); load(2, 1, 8'hA2); load(3, 1, 8'hA3);
    load(0, 1, 8'hA0);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3); exp_q.push_back(8'hA0);
    drain("t2_drain");

    // T3 lock + T4 deferred config
    load(1, 0, 8'h11); load(1, 0, 8'h12); load(1, 1, 8'h13);
    load(0, 1, 8'hB0); load(2, 1, 8'hC2);
    exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h13);
    exp_q.push_back(8'hC2); exp_q.push_back(8'hB0);
    wait_ready(2'd1, "t3_first");
    tick();
    cfg_wr = 1'b1; cfg_sel = 2'd2;
    tick();
    cfg_sel = 2'd3;
    tick();
    cfg_wr = 1'b0; cfg_sel = 2'd0;
    check("t4_pending_set",  cfg_pending,    1);
    check("t4_speed_held",   uart_speed_sel, 4'b1000);
    wait_ready(2'd1, "t3_second");
    wait_ready(2'd1, "t3_third");
    check("t4_pending_lock", cfg_pending,    1);
    wait_ready(2'd2, "t3_src2");
    check("t4_speed_new",    uart_speed_sel, 4'b0010);
    check("t4_pending_clr",  cfg_pending,    0);
    drain("t3_drain");
    cfg_wr = 1'b1; cfg_sel = 2'd3;
    tick();
    cfg_wr = 1'b0; cfg_sel = 2'd0;
    check("t4_sel3_pending", cfg_pending,    0);
    repeat (3) tick();
    check("t4_sel3_speed",   uart_speed_sel, 4'b0010);

    // T5 busy timeout on a locked packet
    load(3, 0, 8'hD3); load(3, 0, 8'hD4); load(3, 1, 8'hD5);
    load(0, 1, 8'hE0);
    exp_q.push_back(8'hD3); exp_q.push_back(8'hD4);
    exp_q.push_back(8'hE0); exp_q.push_back(8'hD5);
    drain("t5_drain");
    check("t5_err_count", n_err, 1);

    // T6 lock stall release
    load(1, 0, 8'hF1); load(2, 1, 8'h62);
    exp_q.push_back(8'hF1); exp_q.push_back(8'h62);
    wait_ready(2'd1, "t6_owner");
    repeat (10) tick();
    check("t6_lock_held", grant_active, 1);
    check("t6_blocked",   req_ready,    0);
    wait_ready(2'd2, "t6_release");
    check("t6_release_cycle", cyc, fall_cyc + 1 + LT);
    drain("t6_drain");

    // T1 reset while in WAIT_DONE, with a baud change pending
    load(0, 1, 8'h55);
    exp_q.push_back(8'h55);
    wait_ready(2'd0, "t1_grant");
    repeat (2) tick();
    cfg_wr = 1'b1; cfg_sel = 2'd1;
    tick();
    cfg_wr = 1'b0; cfg_sel = 2'd0;
    check("t1_pending_before", cfg_pending, 1);
    check("t1_busy_before",    uart_tx_busy, 1);
    rst = 1'b1;
    #1;
    check("t1_uart_wr",  uart_wr,        0);
    check("t1_ready",    req_ready,      0);
    check("t1_speed",    uart_speed_sel, 4'b1000);
    check("t1_pending",  cfg_pending,    0);
    tick();
    check("t1_active",   grant_active,   0);
    check("t1_state",    state_dbg,      0);
    rst = 1'b0;
    repeat (8) tick();
    // pointer back at NUM_REQ-1: source 0 first
    load(1, 1, 8'h78); load(0, 1, 8'h77);
    exp_q.push_back(8'h77); exp_q.push_back(8'h78);
    drain("t1_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
